// File: rtl/div_pipe8_unit_if.sv
// Issue/result bundle of the 8-stage pipelined divider: decode-side issue,
// per-stage busy vectors for hazard checks, and the writeback port.
interface div_pipe8_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_signed;
    logic            in_get_rem;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_dividend;
    logic [XLEN-1:0] in_divisor;

    logic [6:0]      div_busy_0;
    logic [6:0]      div_busy_1;
    logic [6:0]      div_busy_2;
    logic [6:0]      div_busy_3;
    logic [6:0]      div_busy_4;
    logic [6:0]      div_busy_5;
    logic [6:0]      div_busy_6;
    logic [6:0]      div_busy_7;

    logic            out_valid;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_result;

    modport master (
        output in_valid, in_signed, in_get_rem, in_rd, in_dividend, in_divisor,
        input  div_busy_0, div_busy_1, div_busy_2, div_busy_3,
               div_busy_4, div_busy_5, div_busy_6, div_busy_7,
        input  out_valid, out_rd, out_result
    );

    modport slave (
        input  in_valid, in_signed, in_get_rem, in_rd, in_dividend, in_divisor,
        output div_busy_0, div_busy_1, div_busy_2, div_busy_3,
               div_busy_4, div_busy_5, div_busy_6, div_busy_7,
        output out_valid, out_rd, out_result
    );
endinterface

// File: rtl/div_pipe8_unit.sv
// Fully pipelined radix-2 restoring divider for DIV/DIVU/REM/REMU: 4 quotient
// bits per stage, fixed 8-cycle latency, one op per cycle, never stalls.
module div_pipe8_unit #(
    parameter int XLEN           = 32,
    parameter int STAGES         = 8,
    parameter int BITS_PER_STAGE = XLEN / STAGES
) (
    input  logic            clk,
    input  logic            rst,
    div_pipe8_unit_if.slave bus
);
    localparam int unsigned LP_BPS = BITS_PER_STAGE;

    typedef struct packed {
        logic            get_rem;
        logic            neg_q;
        logic            neg_r;
        logic [4:0]      rd;
        logic [XLEN-1:0] rem;
        logic [XLEN-1:0] quo;
    } stage_t;

    logic [STAGES-1:0] r_valid;
    stage_t            r_stage [STAGES];
    // The last stage never iterates again, so it needs no divisor copy.
    logic [XLEN-1:0]   r_dvsr  [STAGES-1];

    stage_t            w_entry;
    logic [XLEN-1:0]   w_abs_dvsr;
    stage_t            w_next  [STAGES];
    logic [XLEN-1:0]   w_q;
    logic [XLEN-1:0]   w_r;

    // quo doubles as the dividend shift register: its msb feeds rem, the new
    // quotient bit enters at the bottom.
    function automatic stage_t f_step(input stage_t s, input logic [XLEN-1:0] dvsr);
        stage_t          w_s;
        logic [XLEN:0]   w_shift;
        w_s = s;
        for (int unsigned i = 0; i < LP_BPS; i++) begin
            w_shift = {w_s.rem, w_s.quo[XLEN-1]};
            if (w_shift >= {1'b0, dvsr}) begin
                w_shift = w_shift - {1'b0, dvsr};
                w_s.quo = {w_s.quo[XLEN-2:0], 1'b1};
            end else begin
                w_s.quo = {w_s.quo[XLEN-2:0], 1'b0};
            end
            w_s.rem = w_shift[XLEN-1:0];
        end
        return w_s;
    endfunction

    function automatic logic [6:0] f_busy(input logic v, input stage_t s);
        return v ? {1'b1, s.get_rem, s.rd} : 7'b0;
    endfunction

    always_comb begin
        w_entry     = '0;
        w_abs_dvsr  = (bus.in_signed && bus.in_divisor[XLEN-1]) ? -bus.in_divisor
                                                                : bus.in_divisor;
        w_entry.quo = (bus.in_signed && bus.in_dividend[XLEN-1]) ? -bus.in_dividend
                                                                 : bus.in_dividend;
        w_entry.rem     = '0;
        w_entry.get_rem = bus.in_get_rem;
        w_entry.rd      = bus.in_rd;
        // A zero divisor must keep the all-ones quotient unsigned.
        w_entry.neg_q   = bus.in_signed & (bus.in_dividend[XLEN-1] ^ bus.in_divisor[XLEN-1])
                          & (bus.in_divisor != '0);
        w_entry.neg_r   = bus.in_signed & bus.in_dividend[XLEN-1];
    end

    always_comb begin
        w_next[0] = f_step(w_entry, w_abs_dvsr);
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_next[k] = f_step(r_stage[k-1], r_dvsr[k-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= {r_valid[STAGES-2:0], bus.in_valid};
        end
    end

    // Payload is left unreset; every consumer is gated by r_valid.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            r_stage[0] <= w_next[0];
            r_dvsr[0]  <= w_abs_dvsr;
        end
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (r_valid[k-1]) begin
                r_stage[k] <= w_next[k];
            end
        end
        for (int unsigned k = 1; k < STAGES - 1; k++) begin
            if (r_valid[k-1]) begin
                r_dvsr[k] <= r_dvsr[k-1];
            end
        end
    end

    assign bus.div_busy_0 = f_busy(r_valid[0], r_stage[0]);
    assign bus.div_busy_1 = f_busy(r_valid[1], r_stage[1]);
    assign bus.div_busy_2 = f_busy(r_valid[2], r_stage[2]);
    assign bus.div_busy_3 = f_busy(r_valid[3], r_stage[3]);
    assign bus.div_busy_4 = f_busy(r_valid[4], r_stage[4]);
    assign bus.div_busy_5 = f_busy(r_valid[5], r_stage[5]);
    assign bus.div_busy_6 = f_busy(r_valid[6], r_stage[6]);
    assign bus.div_busy_7 = f_busy(r_valid[7], r_stage[7]);

    always_comb begin
        w_q = r_stage[STAGES-1].neg_q ? -r_stage[STAGES-1].quo : r_stage[STAGES-1].quo;
        w_r = r_stage[STAGES-1].neg_r ? -r_stage[STAGES-1].rem : r_stage[STAGES-1].rem;
        bus.out_valid  = r_valid[STAGES-1];
        bus.out_rd     = r_valid[STAGES-1] ? r_stage[STAGES-1].rd : '0;
        bus.out_result = '0;
        if (r_valid[STAGES-1]) begin
            bus.out_result = r_stage[STAGES-1].get_rem ? w_r : w_q;
        end
    end
endmodule

// File: tb/tb_div_pipe8_unit.sv
// Self-checking bench for div_pipe8_unit: per-cycle issue history plus an
// arithmetic reference, with directed literal checks and randomized traffic.
module tb_div_pipe8_unit;
    localparam int MAXC = 2048;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    div_pipe8_unit_if #(.XLEN(32)) ifc ();

    div_pipe8_unit #(.XLEN(32), .STAGES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [6:0] busy [8];
    assign busy[0] = ifc.div_busy_0;
    assign busy[1] = ifc.div_busy_1;
    assign busy[2] = ifc.div_busy_2;
    assign busy[3] = ifc.div_busy_3;
    assign busy[4] = ifc.div_busy_4;
    assign busy[5] = ifc.div_busy_5;
    assign busy[6] = ifc.div_busy_6;
    assign busy[7] = ifc.div_busy_7;

    // Issue history indexed by the cycle in which the op was presented.
    logic        h_v   [MAXC];
    logic        h_gr  [MAXC];
    logic [4:0]  h_rd  [MAXC];
    logic [31:0] h_res [MAXC];
    logic        h_rst [MAXC];

    function automatic logic [31:0] ref_div(input logic sg, input logic gr,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return gr ? a : 32'hFFFF_FFFF;
        if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return gr ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return gr ? 32'(sa % sb) : 32'(sa / sb);
        end
        return gr ? a % b : a / b;
    endfunction

    // An op issued in cycle idx survives to cycle t unless a reset edge fell between.
    function automatic logic alive(input int idx, input int t);
        if (idx < 0 || !h_v[idx]) return 1'b0;
        for (int r = idx; r < t; r++) begin
            if (h_rst[r]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            for (int k = 0; k < 8; k++) begin
                int idx;
                logic [6:0] eb;
                idx = cyc - 1 - k;
                eb  = alive(idx, cyc) ? {1'b1, h_gr[idx], h_rd[idx]} : 7'b0;
                chk($sformatf("busy%0d", k), {25'b0, busy[k]}, {25'b0, eb});
            end
            begin
                int idx;
                logic ok;
                idx = cyc - 8;
                ok  = alive(idx, cyc);
                chk("out_valid", {31'b0, ifc.out_valid}, {31'b0, ok});
                chk("out_rd", {27'b0, ifc.out_rd}, ok ? {27'b0, h_rd[idx]} : 32'd0);
                chk("out_result", ifc.out_result, ok ? h_res[idx] : 32'd0);
            end
        end
    end

    task automatic drive(input logic v, input logic sg, input logic gr, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic r);
        ifc.in_valid    = v;
        ifc.in_signed   = sg;
        ifc.in_get_rem  = gr;
        ifc.in_rd       = rd;
        ifc.in_dividend = a;
        ifc.in_divisor  = b;
        rst             = r;
        h_v[cyc]   = v;
        h_gr[cyc]  = gr;
        h_rd[cyc]  = rd;
        h_res[cyc] = ref_div(sg, gr, a, b);
        h_rst[cyc] = !r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        next_cycle();
        drive(1'b0, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, 1'b1);
    endtask

    task automatic directed(input string name, input logic sg, input logic gr, input logic [4:0] rd,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        next_cycle();
        drive(1'b1, sg, gr, rd, a, b, 1'b1);
        for (int k = 0; k < 8; k++) begin
            idle();
            @(negedge clk);
            chk({name, "_busy"}, {25'b0, busy[k]}, {25'b0, 1'b1, gr, rd});
        end
        chk({name, "_valid"}, {31'b0, ifc.out_valid}, 32'd1);
        chk({name, "_rd"}, {27'b0, ifc.out_rd}, {27'b0, rd});
        chk({name, "_res"}, ifc.out_result, exp);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            h_v[i] = 1'b0; h_gr[i] = 1'b0; h_rd[i] = '0; h_res[i] = '0; h_rst[i] = 1'b0;
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        next_cycle(); drive(1'b1, 1'b0, 1'b0, 5'd9, 32'd10, 32'd3, 1'b0);
        idle();
        @(negedge clk);
        chk("reset_busy7", {25'b0, ifc.div_busy_7}, 32'd0);
        chk("reset_out_valid", {31'b0, ifc.out_valid}, 32'd0);

        directed("divu_100_7",   1'b0, 1'b0, 5'd5, 32'd100,         32'd7,         32'd14);
        directed("rem_m7_2",     1'b1, 1'b1, 5'd3, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF);
        directed("div_m7_2",     1'b1, 1'b0, 5'd3, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD);
        directed("div_by0",      1'b1, 1'b0, 5'd4, 32'h1234_5678,   32'd0,         32'hFFFF_FFFF);
        directed("remu_by0",     1'b0, 1'b1, 5'd6, 32'h1234_5678,   32'd0,         32'h1234_5678);
        directed("rem_m5_by0",   1'b1, 1'b1, 5'd7, 32'hFFFF_FFFB,   32'd0,         32'hFFFF_FFFB);
        directed("div_ovf",      1'b1, 1'b0, 5'd8, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000);
        directed("rem_ovf",      1'b1, 1'b1, 5'd8, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0);
        directed("divu_rd0",     1'b0, 1'b0, 5'd0, 32'd77,          32'd7,         32'd11);

        // Back-to-back: rd 1..8 issued on consecutive cycles.
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            drive(1'b1, 1'b0, 1'b0, 5'(i), 32'(1000 * i), 32'(i + 2), 1'b1);
        end
        idle();
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("b2b_rd%0d", k), {27'b0, busy[k][4:0]}, 32'(8 - k));
        end
        chk("b2b_first_res", ifc.out_result, 32'd333);
        for (int i = 0; i < 8; i++) idle();

        // Reset mid-flight: three ops, reset edge four cycles after the first.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1'b1, 1'b1, 1'($urandom), 5'(20 + i), pick(), pick(), 1'b1);
        end
        idle();
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 5'd31, 32'd50, 32'd5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle();
            @(negedge clk);
            chk("rst_flush_valid", {31'b0, ifc.out_valid}, 32'd0);
            chk("rst_flush_busy0", {25'b0, ifc.div_busy_0}, 32'd0);
        end
        directed("after_rst", 1'b0, 1'b1, 5'd12, 32'd50, 32'd7, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            next_cycle();
            if ($urandom_range(0, 9) < 7) begin
                drive(1'b1, 1'($urandom), 1'($urandom), 5'($urandom), pick(), pick(),
                      !($urandom_range(0, 199) == 0));
            end else begin
                drive(1'b0, 1'b0, 1'b0, 5'd0, $urandom, $urandom, 1'b1);
            end
        end
        for (int i = 0; i < 10; i++) idle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_pipe8_unit.md
Name: div_pipe8_unit

Overview:
- Fully pipelined 8-stage radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Sits beside the ALU in the execute stage. Accepts at most one op per cycle from the ID/EX register and writes its result back after a fixed 8-cycle latency.
- Publishes a per-stage occupancy/destination vector (div_busy_0..7). Decode uses it for RAW hazard stalls and writeback-collision avoidance.
- Never stalls and has no flush. Once an op is accepted, it completes.

Parameters:
- XLEN, 32, operand/result width.
- STAGES, 8, number of pipeline stages. Must equal 8, because the busy port list is fixed.
- BITS_PER_STAGE, XLEN/STAGES (4), quotient bits resolved per stage. XLEN must be divisible by STAGES.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset (0 = reset).
- in_valid  in  1  issue a divide op this cycle (driven by x_is_div_op_out).
- in_signed  in  1  1 = DIV/REM, 0 = DIVU/REMU.
- in_get_rem  in  1  1 = return remainder, 0 = return quotient.
- in_rd  in  5  destination register.
- in_dividend  in  XLEN  rs1 operand (already forwarded).
- in_divisor  in  XLEN  rs2 operand (already forwarded).
- div_busy_0 .. div_busy_7  out  7 each  stage k status: [6] valid, [5] get_rem flag, [4:0] rd.
- out_valid  out  1  result available for writeback this cycle.
- out_rd  out  5  destination of the result.
- out_result  out  XLEN  quotient or remainder, sign-corrected.

Behaviour:
- Reset (rst=0 at an edge): all stage valid bits clear, so every div_busy_k = 7'b0. out_valid=0, out_rd=0, out_result=0 (outputs are gated by the stage-7 valid bit). Datapath registers may hold X. Reset mid-operation drops all in-flight ops with no output.
- Entry (edge where in_valid=1):
  - Compute abs(dividend) and abs(divisor) when in_signed=1; otherwise use raw values.
  - Record neg_q = in_signed & (dividend[31]^divisor[31]) & (divisor!=0).
  - Record neg_r = in_signed & dividend[31].
  - Perform the first BITS_PER_STAGE restoring iterations combinationally and capture the result into stage 0 with valid=1.
- Advance: each edge, stage k copies to stage k+1 after performing BITS_PER_STAGE more iterations. Stage 0 loads the new op, or invalid if in_valid=0. There is no hold or bubble squeeze.
- Iteration: rem = {rem[XLEN-2:0], dividend_msb}. If rem >= divisor, then rem -= divisor and qbit = 1; otherwise qbit = 0. Keep a 33-bit compare internally. No wrap is permitted.
- Stage 7 holds the full unsigned quotient/remainder. Output is combinational from stage 7:
  - out_valid = stage7.valid; out_rd = stage7.rd.
  - out_result = get_rem ? (neg_r ? -r : r) : (neg_q ? -q : q).
- Timing: in_valid high in cycle c gives div_busy_k[6]=1 in cycle c+1+k and out_valid=1 in cycle c+8 (concurrently with div_busy_7).
- Throughput: 8 ops can be in flight, one per stage. Back-to-back issue is legal every cycle.
- Divide by zero: the unsigned iteration naturally yields q=all ones and r=dividend. The sign fix must not alter this (neg_q forced 0). Required results: quotient 0xFFFFFFFF; remainder = original signed/unsigned dividend (neg_r applied to abs value restores it).
- Signed overflow (0x80000000 / 0xFFFFFFFF, signed): quotient 0x80000000, remainder 0. This falls out of abs/negate in XLEN bits; verify it explicitly.
- rd=0 ops are processed normally: busy valid=1 and out_valid=1 with out_rd=0. The consumer suppresses the write.
- Busy bit [5] mirrors get_rem for debug only. Decode ignores it.
- in_* are sampled only when in_valid=1. Otherwise their values are don't-care.

Test Plan:
- Unsigned: in_valid=1 at cycle c, DIVU 100/7 rd=5 → out_valid=1 at c+8, out_rd=5, out_result=14. div_busy_k=7'b1_0_00101 at c+1+k only.
- Signed remainder: REM -7 % 2 (0xFFFFFFF9, 2) rd=3 → out_result=0xFFFFFFFF (-1). DIV of the same operands → 0xFFFFFFFD (-3).
- Divide by zero: DIV 0x12345678/0 → 0xFFFFFFFF. REMU 0x12345678/0 → 0x12345678. REM -5/0 → 0xFFFFFFFB.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- Back-to-back: 8 consecutive issues, rd=1..8 with distinct operands → div_busy_0..7 at c+8 hold rd 8..1 respectively. Results emerge on cycles c+8..c+15 in issue order with correct values. No gaps when issues are continuous.
- Reset mid-flight: issue 3 ops, assert rst=0 for one edge at c+4 → from c+5 all div_busy=0 and out_valid stays 0 through c+12. A new op issued after reset completes correctly 8 cycles later.
